// File: rtl/xc20xx_cfg_loader.sv
// ============================================================================
// Module   : xc20xx_cfg_loader
// Brief    : Serial configuration bitstream loader for the XC20XX fabric.
//            Parses preamble, length count, separator and framed data, and
//            writes each completed frame to configuration memory.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module xc20xx_cfg_loader #(
    parameter int FRAME_BITS = 46,
    parameter int NUM_FRAMES = 160,
    parameter int ADDR_W     = 8,
    parameter int LEN_W      = 24
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  DIN,
    input  logic                  DIN_VALID,
    output logic [FRAME_BITS-1:0] FRAME_DATA,
    output logic [ADDR_W-1:0]     FRAME_ADDR,
    output logic                  FRAME_WE,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  ERR
);

    // Field counter must cover the longest field (length count or frame data).
    localparam int c_FC_MAX = (LEN_W > FRAME_BITS) ? LEN_W : FRAME_BITS;
    localparam int c_FC_W   = $clog2(c_FC_MAX + 1);

    localparam logic [c_FC_W-1:0] c_LEN_LAST  = c_FC_W'(LEN_W - 1);
    localparam logic [c_FC_W-1:0] c_DATA_LAST = c_FC_W'(FRAME_BITS - 1);
    localparam logic [c_FC_W-1:0] c_SEP_LAST  = c_FC_W'(3);
    localparam logic [c_FC_W-1:0] c_STOP_LAST = c_FC_W'(2);
    localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(NUM_FRAMES - 1);
    localparam logic [LEN_W-1:0]  c_PRE_BITS  = LEN_W'(4);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN   = 3'd1,
        ST_SEP   = 3'd2,
        ST_START = 3'd3,
        ST_DATA  = 3'd4,
        ST_STOP  = 3'd5,
        ST_DONE  = 3'd6,
        ST_ERR   = 3'd7
    } state_t;

    state_t                r_state;
    logic [2:0]            r_hist;     // last three accepted bits while idle
    logic [2:0]            r_hfill;    // marks which history slots hold real bits
    logic [LEN_W-1:0]      r_len;
    logic [LEN_W-1:0]      r_bcnt;
    logic [c_FC_W-1:0]     r_fcnt;
    logic [FRAME_BITS-1:0] r_shift;
    logic [FRAME_BITS-1:0] r_frame_data;
    logic [ADDR_W-1:0]     r_addr;
    logic                  r_we;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;

    logic [3:0]            w_hist_nxt;
    logic [3:0]            w_hfill_nxt;
    logic                  w_pre_hit;
    logic [LEN_W-1:0]      w_bcnt_inc;

    // Preamble detection needs four genuinely received bits, so a freshly
    // reset history of zeros cannot fake the leading 0,0 of the pattern.
    assign w_hist_nxt  = {r_hist, DIN};
    assign w_hfill_nxt = {r_hfill, 1'b1};
    assign w_pre_hit   = (w_hfill_nxt == 4'b1111) && (w_hist_nxt == 4'b0010);
    assign w_bcnt_inc  = (&r_bcnt) ? r_bcnt : r_bcnt + 1'b1;

    // Bitstream parser; state advances only on accepted bits, write strobe is per-cycle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state      <= ST_IDLE;
            r_hist       <= '0;
            r_hfill      <= '0;
            r_len        <= '0;
            r_bcnt       <= '0;
            r_fcnt       <= '0;
            r_shift      <= '0;
            r_frame_data <= '0;
            r_addr       <= '0;
            r_we         <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_we <= 1'b0;
            // Address moves on to the next frame once the strobe has been seen.
            if (r_we) begin
                r_addr <= r_addr + 1'b1;
            end
            if (DIN_VALID) begin
                case (r_state)
                    ST_IDLE: begin
                        r_hist  <= w_hist_nxt[2:0];
                        r_hfill <= w_hfill_nxt[2:0];
                        if (w_pre_hit) begin
                            r_state <= ST_LEN;
                            r_busy  <= 1'b1;
                            r_bcnt  <= c_PRE_BITS;
                            r_fcnt  <= '0;
                        end
                    end
                    ST_LEN: begin
                        r_bcnt <= w_bcnt_inc;
                        r_len  <= {r_len[LEN_W-2:0], DIN};
                        if (r_fcnt == c_LEN_LAST) begin
                            r_fcnt  <= '0;
                            r_state <= ST_SEP;
                        end else begin
                            r_fcnt <= r_fcnt + 1'b1;
                        end
                    end
                    ST_SEP: begin
                        r_bcnt <= w_bcnt_inc;
                        if (!DIN) begin
                            r_state <= ST_ERR;
                            r_busy  <= 1'b0;
                            r_err   <= 1'b1;
                        end else if (r_fcnt == c_SEP_LAST) begin
                            r_fcnt  <= '0;
                            r_state <= ST_START;
                        end else begin
                            r_fcnt <= r_fcnt + 1'b1;
                        end
                    end
                    ST_START: begin
                        r_bcnt <= w_bcnt_inc;
                        if (DIN) begin
                            r_state <= ST_ERR;
                            r_busy  <= 1'b0;
                            r_err   <= 1'b1;
                        end else begin
                            r_fcnt  <= '0;
                            r_state <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        r_bcnt  <= w_bcnt_inc;
                        r_shift <= {r_shift[FRAME_BITS-2:0], DIN};
                        if (r_fcnt == c_DATA_LAST) begin
                            r_fcnt  <= '0;
                            r_state <= ST_STOP;
                        end else begin
                            r_fcnt <= r_fcnt + 1'b1;
                        end
                    end
                    ST_STOP: begin
                        r_bcnt <= w_bcnt_inc;
                        if (!DIN) begin
                            r_state <= ST_ERR;
                            r_busy  <= 1'b0;
                            r_err   <= 1'b1;
                        end else if (r_fcnt == c_STOP_LAST) begin
                            r_fcnt       <= '0;
                            r_frame_data <= r_shift;
                            r_we         <= 1'b1;
                            if (r_addr < c_LAST_ADDR) begin
                                r_state <= ST_START;
                            end else if (w_bcnt_inc == r_len) begin
                                r_state <= ST_DONE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= ST_ERR;
                                r_busy  <= 1'b0;
                                r_err   <= 1'b1;
                            end
                        end else begin
                            r_fcnt <= r_fcnt + 1'b1;
                        end
                    end
                    default: begin
                        // DONE and ERR are terminal until reset.
                    end
                endcase
            end
        end
    end

    assign FRAME_DATA = r_frame_data;
    assign FRAME_ADDR = r_addr;
    assign FRAME_WE   = r_we;
    assign BUSY       = r_busy;
    assign DONE       = r_done;
    assign ERR        = r_err;

endmodule

`default_nettype wire

// File: tb/tb_xc20xx_cfg_loader.sv
// ============================================================================
// Module   : tb_xc20xx_cfg_loader
// Brief    : Scoreboard bench for the serial configuration loader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_xc20xx_cfg_loader;

    localparam int FB    = 4;
    localparam int NF    = 2;
    localparam int AW    = 4;
    localparam int LW    = 24;
    localparam int TOTAL = 4 + LW + 4 + NF * (FB + 4);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          din = 1'b0;
    logic          din_valid = 1'b0;
    logic [FB-1:0] frame_data;
    logic [AW-1:0] frame_addr;
    logic          frame_we;
    logic          busy;
    logic          done;
    logic          err;

    always #5 clk = ~clk;

    xc20xx_cfg_loader #(
        .FRAME_BITS (FB),
        .NUM_FRAMES (NF),
        .ADDR_W     (AW),
        .LEN_W      (LW)
    ) dut (
        .CLK        (clk),
        .RST        (rst),
        .DIN        (din),
        .DIN_VALID  (din_valid),
        .FRAME_DATA (frame_data),
        .FRAME_ADDR (frame_addr),
        .FRAME_WE   (frame_we),
        .BUSY       (busy),
        .DONE       (done),
        .ERR        (err)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [FB-1:0] data;
    } wr_t;

    wr_t           exp_q[$];
    logic          bits[$];
    int            n_chk = 0;
    int            n_pass = 0;
    logic          prev_we = 1'b0;
    logic [FB-1:0] fd [NF];
    logic          exp_done;
    logic          exp_err;
    logic [FB-1:0] exp_last;
    logic [AW-1:0] exp_addr;
    int            busy_idx;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Monitor: every write strobe is matched against the scoreboard queue.
    always @(negedge clk) begin
        if (frame_we) begin
            chk("we_width", {63'd0, prev_we}, 64'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {60'd0, frame_addr}, 64'hFFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", {60'd0, frame_addr}, {60'd0, e.addr});
                chk("wr_data", {60'd0, frame_data}, {60'd0, e.data});
            end
        end
        prev_we = frame_we;
    end

    // Builds the serial stream from fields and derives the expected outcome
    // directly from the bitstream format rules.
    // kind: 0 clean, 1 bad start bit in frame efr, 2 bad stop bit epos in frame efr
    task automatic build_case(input int len, input logic [3:0] sep, input int kind,
                              input int efr, input int epos, input int lead);
        logic [LW-1:0] lv;
        int nfr;
        logic e;
        lv = LW'(len);
        bits.delete();
        repeat (lead) bits.push_back(1'b1);
        bits.push_back(1'b0); bits.push_back(1'b0);
        bits.push_back(1'b1); bits.push_back(1'b0);
        busy_idx = lead + 3;
        for (int i = LW - 1; i >= 0; i--) bits.push_back(lv[i]);
        for (int i = 3; i >= 0; i--) bits.push_back(sep[i]);
        for (int f = 0; f < NF; f++) begin
            logic [FB-1:0] d;
            d = fd[f];
            bits.push_back((kind == 1) && (f == efr));
            for (int i = FB - 1; i >= 0; i--) bits.push_back(d[i]);
            for (int s = 0; s < 3; s++) bits.push_back(!((kind == 2) && (f == efr) && (s == epos)));
        end
        repeat (6) bits.push_back(1'($urandom));

        if (sep != 4'hF) begin
            nfr = 0; e = 1'b1;
        end else if (kind != 0) begin
            nfr = efr; e = 1'b1;
        end else begin
            nfr = NF; e = (len != TOTAL);
        end
        exp_err  = e;
        exp_done = !e;
        for (int i = 0; i < nfr; i++) exp_q.push_back({AW'(i), fd[i]});
        exp_last = (nfr > 0) ? fd[nfr-1] : '0;
        exp_addr = AW'(nfr);
    endtask

    // Sends the first n stream bits; gap < 0 means random 0..2 idle cycles per bit.
    task automatic send_bits(input int n, input int gap);
        int g;
        for (int i = 0; i < n && i < bits.size(); i++) begin
            din = bits[i];
            din_valid = 1'b1;
            @(posedge clk); #1;
            din_valid = 1'b0;
            if (i == busy_idx) chk("busy_after_preamble", {63'd0, busy}, 64'd1);
            g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
            repeat (g) begin
                din = 1'($urandom);
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic finish_case(input string nm);
        repeat (3) @(posedge clk);
        #1;
        chk({nm, "_done"}, {63'd0, done}, {63'd0, exp_done});
        chk({nm, "_err"},  {63'd0, err},  {63'd0, exp_err});
        chk({nm, "_busy"}, {63'd0, busy}, 64'd0);
        chk({nm, "_addr"}, {60'd0, frame_addr}, {60'd0, exp_addr});
        chk({nm, "_data"}, {60'd0, frame_data}, {60'd0, exp_last});
        chk({nm, "_pending"}, 64'(exp_q.size()), 64'd0);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        chk("rst_data", {60'd0, frame_data}, 64'd0);
        chk("rst_addr", {60'd0, frame_addr}, 64'd0);
        chk("rst_we",   {63'd0, frame_we}, 64'd0);
        chk("rst_flags", {61'd0, busy, done, err}, 64'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        @(posedge clk); #1;
        do_reset();

        // Nominal stream
        fd[0] = 4'b1010; fd[1] = 4'b0110;
        build_case(48, 4'hF, 0, 0, 0, 2);
        send_bits(bits.size(), 0);
        finish_case("nominal");

        // Length count one short
        do_reset();
        build_case(47, 4'hF, 0, 0, 0, 2);
        send_bits(bits.size(), 0);
        finish_case("len47");

        // Second stop bit of frame 0 cleared
        do_reset();
        build_case(48, 4'hF, 2, 0, 1, 2);
        send_bits(bits.size(), 0);
        finish_case("badstop");

        // Three idle cycles after every accepted bit
        do_reset();
        build_case(48, 4'hF, 0, 0, 0, 2);
        send_bits(bits.size(), 3);
        finish_case("gaps");

        // Reset during frame 1 data, then a full reload
        do_reset();
        build_case(48, 4'hF, 0, 0, 0, 2);
        send_bits(2 + 4 + LW + 4 + (FB + 4) + 1 + 2, 0);
        do_reset();
        build_case(48, 4'hF, 0, 0, 0, 2);
        send_bits(bits.size(), 0);
        finish_case("reload");

        // Bad separator
        do_reset();
        build_case(48, 4'b1101, 0, 0, 0, 2);
        send_bits(bits.size(), 0);
        finish_case("badsep");

        // 0,1,0,0 while idle must not start a load
        do_reset();
        bits.delete();
        bits.push_back(1'b0); bits.push_back(1'b1);
        bits.push_back(1'b0); bits.push_back(1'b0);
        busy_idx = -1;
        send_bits(4, 0);
        chk("idle_0100_busy", {63'd0, busy}, 64'd0);
        build_case(48, 4'hF, 0, 0, 0, 0);
        send_bits(bits.size(), 0);
        finish_case("after_0100");

        // Randomised streams
        for (int t = 0; t < 12; t++) begin
            int kind, len, efr, epos;
            logic [3:0] sep;
            do_reset();
            for (int f = 0; f < NF; f++) fd[f] = FB'($urandom);
            kind = $urandom_range(0, 3);
            len  = ($urandom_range(0, 1) == 1) ? TOTAL : int'($urandom_range(0, 100));
            efr  = $urandom_range(0, NF - 1);
            epos = $urandom_range(0, 2);
            sep  = 4'hF;
            if (kind == 3) begin
                sep  = 4'($urandom_range(0, 14));
                kind = 0;
            end
            build_case(len, sep, kind, efr, epos, $urandom_range(0, 3));
            send_bits(bits.size(), -1);
            finish_case("random");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
